// File: rtl/rfwa_pkg.sv
// rtl/rfwa_pkg.sv - shared constants and grant encoding for the register-file write arbiter
package rfwa_pkg;

    localparam logic [4:0] ZERO_ADDR    = 5'd0;
    localparam logic [4:0] KREG_DEFAULT = 5'd26;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_TRAP,
        GNT_UART
    } grant_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writer-side and register-file-side signals of the write arbiter
interface rfwa_if;

    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        trap_req;
    logic [31:0] trap_data;
    logic        trap_ack;
    logic        uart_valid;
    logic [4:0]  uart_addr;
    logic [31:0] uart_data;
    logic        uart_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        pipe_hold;

    modport master (
        output wb_we, wb_addr, wb_data, trap_req, trap_data,
        output uart_valid, uart_addr, uart_data,
        input  trap_ack, uart_ready, rf_we, rf_addr, rf_data, pipe_hold
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, trap_req, trap_data,
        input  uart_valid, uart_addr, uart_data,
        output trap_ack, uart_ready, rf_we, rf_addr, rf_data, pipe_hold
    );

endinterface

// File: rtl/rfwa_age_counter.sv
// rtl/rfwa_age_counter.sv - saturating wait counter for the buffered UART write
module rfwa_age_counter #(
    parameter logic [7:0] LIMIT = 8'd8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);

    logic [7:0] r_count;

    // Saturate so a long starvation cannot wrap and drop the hold request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_en && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count >= LIMIT);

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - merges WB, trap and UART writes onto one register-file port
// Optional UART starvation aging is built when RFWA_AGING_EN is defined.
module regfile_write_arbiter
    import rfwa_pkg::*;
#(
    parameter int unsigned AGE_LIMIT = 8,
    parameter logic [4:0]  KREG      = KREG_DEFAULT
) (
    input logic   clk,
    input logic   rst_n,
    rfwa_if.slave rf_bus
);

    logic        r_trap_pend;
    logic [31:0] r_trap_data;
    logic        r_uart_full;
    logic [4:0]  r_uart_addr;
    logic [31:0] r_uart_data;

    grant_t      w_gnt;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        w_age_expired;

    // Gated by rst_n so the port is silent while reset is held.
    always_comb begin
        w_gnt = GNT_NONE;
        if (!rst_n) begin
            w_gnt = GNT_NONE;
        end else if (rf_bus.wb_we) begin
            w_gnt = GNT_WB;
        end else if (r_trap_pend || rf_bus.trap_req) begin
            w_gnt = GNT_TRAP;
        end else if (r_uart_full) begin
            w_gnt = GNT_UART;
        end
    end

    always_comb begin
        w_addr = ZERO_ADDR;
        w_data = 32'd0;
        case (w_gnt)
            GNT_WB: begin
                w_addr = rf_bus.wb_addr;
                w_data = rf_bus.wb_data;
            end
            GNT_TRAP: begin
                w_addr = KREG;
                w_data = r_trap_pend ? r_trap_data : rf_bus.trap_data;
            end
            GNT_UART: begin
                w_addr = r_uart_addr;
                w_data = r_uart_data;
            end
            default: begin
                w_addr = ZERO_ADDR;
                w_data = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap_pend <= 1'b0;
            r_trap_data <= 32'd0;
            r_uart_full <= 1'b0;
            r_uart_addr <= 5'd0;
            r_uart_data <= 32'd0;
        end else begin
            if (r_trap_pend && (w_gnt == GNT_TRAP)) begin
                r_trap_pend <= 1'b0;
            end else if (rf_bus.trap_req && rf_bus.wb_we && !r_trap_pend) begin
                r_trap_pend <= 1'b1;
                r_trap_data <= rf_bus.trap_data;
            end
            if (w_gnt == GNT_UART) begin
                r_uart_full <= 1'b0;
            end else if (rf_bus.uart_valid && !r_uart_full) begin
                r_uart_full <= 1'b1;
                r_uart_addr <= rf_bus.uart_addr;
                r_uart_data <= rf_bus.uart_data;
            end
        end
    end

`ifdef RFWA_AGING_EN
    rfwa_age_counter #(
        .LIMIT (8'(AGE_LIMIT))
    ) u_age_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_uart_full && (w_gnt != GNT_UART)),
        .i_clr     (w_gnt == GNT_UART),
        .o_expired (w_age_expired)
    );
`else
    assign w_age_expired = 1'b0;
`endif

    assign rf_bus.rf_we      = (w_gnt != GNT_NONE) && (w_addr != ZERO_ADDR);
    assign rf_bus.rf_addr    = w_addr;
    assign rf_bus.rf_data    = w_data;
    assign rf_bus.trap_ack   = (w_gnt == GNT_TRAP);
    assign rf_bus.uart_ready = !r_uart_full;
    assign rf_bus.pipe_hold  = r_trap_pend || w_age_expired;

    a_age_limit_range: assert property (@(posedge clk) (AGE_LIMIT >= 1) && (AGE_LIMIT <= 255));

    // A second trap while one is still pending is dropped by the logic above.
    a_no_trap_while_pending: assert property (
        @(posedge clk) disable iff (!rst_n) !(rf_bus.trap_req && r_trap_pend)
    );

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Single-write-port arbiter in front of the ID-stage register file. It merges three writers onto one port: the WB stage, the trap path (which saves the return address into $k0 on interrupt or exception), and the UART receive path. WB is never delayed. The trap and UART writes are held and sequenced into idle WB cycles, and `pipe_hold` requests a pipeline freeze when a held write must be forced through.

## Interface
- `AGE_LIMIT`, default 8: cycles a buffered UART write may wait before `pipe_hold` is forced; legal range 1..255.
- `KREG`, default 5'd26: destination register for trap writes.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wb_we`  in  1  WB write request; always served in the same cycle.
- `wb_addr`  in  5  WB destination register.
- `wb_data`  in  32  WB write data.
- `trap_req`  in  1  single-cycle pulse: trap entry.
- `trap_data`  in  32  return address to store in `KREG`; sampled when `trap_req`=1.
- `trap_ack`  out  1  pulses in the cycle the trap write reaches the port.
- `uart_valid`  in  1  UART write offer.
- `uart_addr`  in  5  UART destination register.
- `uart_data`  in  32  UART write data.
- `uart_ready`  out  1  buffer empty; transfer happens when `uart_valid` and `uart_ready` are both 1.
- `rf_we`  out  1  register-file write enable.
- `rf_addr`  out  5  register-file write address.
- `rf_data`  out  32  register-file write data.
- `pipe_hold`  out  1  freeze request to IF/ID/EX/MEM.

## Operation
- Grant priority each cycle is WB > trap > UART buffer. The grant and the `rf_*` outputs are combinational from the current inputs and state, so there is no added write latency.
- Trap path:
  - If `trap_req`=1 and `wb_we`=0, the trap is written directly: `rf_addr`=`KREG`, `rf_data`=`trap_data`, and `trap_ack`=1 in the same cycle.
  - If `trap_req` and `wb_we` are both 1, `trap_data` is latched into a pending register and `pipe_hold` rises the next cycle.
  - The pending trap is written in the first cycle with `wb_we`=0. `trap_ack` pulses in that cycle, and `pipe_hold` drops the following cycle unless aging still requires it.
- A `trap_req` arriving while a trap is already pending is a protocol violation. It is ignored and flagged by an assertion.
- UART path:
  - One-entry buffer. A handshake transfer loads `uart_addr` and `uart_data`.
  - The buffered write is granted when `wb_we`=0, no trap is pending, and `trap_req`=0. The buffer empties on grant, and `uart_ready` returns to 1 the next cycle.
- Aging (only when compiled in): an 8-bit counter increments each cycle the buffer is full and not granted. When the count reaches `AGE_LIMIT`, `pipe_hold`=1 until the grant. The counter clears on grant.
- $zero rule: any granted write with address 0 is consumed (acked, buffer freed) but drives `rf_we`=0.
- `pipe_hold` = trap pending OR aging expired.

## Timing
- Reset values:
  - `rf_we`=0, `rf_addr`=0, `rf_data`=0.
  - `trap_ack`=0, `pipe_hold`=0.
  - `uart_ready`=1.
  - Trap-pending flag, UART buffer and age counter cleared.
- Reset mid-operation discards any pending trap or buffered UART write. No write is replayed.
- Latency:
  - WB: 0 cycles.
  - Direct trap: 0 cycles.
  - Pending trap: first WB-idle cycle.
  - UART: at least 1 cycle after handshake.
- Simultaneous UART handshake and grant of the old entry is not possible, because `uart_ready`=0 while the buffer is full.

## Configuration
- `RFWA_AGING_EN` defined: age counter present; `pipe_hold` also asserts on UART starvation.
- `RFWA_AGING_EN` undefined: no counter; a UART write may wait indefinitely; `pipe_hold` = trap pending only.

## Structure
- Shared package `rfwa_pkg`:
  - `ZERO_ADDR`=5'd0 and `KREG_DEFAULT`=5'd26.
  - Grant typedef enum {`GNT_NONE`, `GNT_WB`, `GNT_TRAP`, `GNT_UART`}.
- One sub-module: `rfwa_age_counter` (enable, clear, limit compare, expired output), instantiated only under `RFWA_AGING_EN`.

## Test plan
- WB write, addr 5, data 0x1234 -> same cycle `rf_we`=1, `rf_addr`=5, `rf_data`=0x1234.
- `trap_req` with `trap_data`=0x80000010 while `wb_we`=1 for 3 consecutive cycles:
  - `pipe_hold`=1 from cycle+1.
  - Cycle 3 (first WB-idle) writes `KREG`=26 with 0x80000010 and pulses `trap_ack`.
  - `pipe_hold`=0 the next cycle.
- UART handshake, addr 4, data 0xAB, WB idle -> write on the next cycle; `uart_ready` is 0 for exactly 1 cycle.
- UART buffered, `wb_we`=1 continuously, `AGE_LIMIT`=8 -> `pipe_hold`=1 after 8 waiting cycles; with `RFWA_AGING_EN` undefined, `pipe_hold` stays 0.
- UART write to addr 0 -> `rf_we`=0 and `uart_ready` back to 1 the next cycle.
- `rst_n` low with a trap pending and the UART buffer full -> all outputs return to reset values and no write occurs after release.
